// File: rtl/verinject_injection_sequencer.sv
// Drives the shared injector-state bus from an in-order (cycle, bit) schedule.
// One code per edge: clear request, scheduled fire, or idle.
module verinject_injection_sequencer #(
    parameter int FIFO_DEPTH = 8,
    parameter int CYCLE_W    = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        run,
    input  logic                        sched_valid,
    output logic                        sched_ready,
    input  logic [CYCLE_W-1:0]          sched_cycle,
    input  logic [31:0]                 sched_bit,
    input  logic                        clear_req,
    output logic [CYCLE_W-1:0]          cycle_count,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [31:0]                 verinject__injector_state,
    output logic                        missed,
    output logic                        bad_entry,
    output logic [15:0]                 inject_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [31:0]        CODE_IDLE  = 32'hFFFF_FFFF;
    localparam logic [31:0]        CODE_CLEAR = 32'hFFFF_FFFE;
    localparam logic [AW:0]        CNT_ONE    = 1;
    localparam logic [AW-1:0]      PTR_ONE    = 1;
    localparam logic [CYCLE_W-1:0] CYC_ONE    = 1;

    logic [CYCLE_W-1:0] mem_cycle [FIFO_DEPTH];
    logic [31:0]        mem_bit   [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count_next;
    logic [31:0]        state_next;
    logic [CYCLE_W-1:0] head_cycle;
    logic [31:0]        head_bit;
    logic               push;
    logic               store;
    logic               not_empty;
    logic               fire;
    logic               stale;
    logic               pop;

    // Count never exceeds FIFO_DEPTH (a power of two), so the top bit means full.
    assign sched_ready = ~fifo_count[AW];
    assign push        = sched_valid && sched_ready;
    assign store       = push && (sched_bit < CODE_CLEAR);
    assign not_empty   = (fifo_count != '0);
    assign head_cycle  = mem_cycle[rd_ptr];
    assign head_bit    = mem_bit[rd_ptr];

    // A clear request blocks any pop that edge; the blocked head goes stale next edge.
    assign fire  = !clear_req && run && not_empty && (head_cycle == cycle_count);
    assign stale = !clear_req && run && not_empty && (head_cycle <  cycle_count);
    assign pop   = fire || stale;

    always_comb begin
        count_next = fifo_count;
        if (store && !pop) begin
            count_next = fifo_count + CNT_ONE;
        end else if (!store && pop) begin
            count_next = fifo_count - CNT_ONE;
        end
    end

    always_comb begin
        state_next = CODE_IDLE;
        if (clear_req) begin
            state_next = CODE_CLEAR;
        end else if (fire) begin
            state_next = head_bit;
        end
    end

    always_ff @(posedge clock) begin
        if (store) begin
            mem_cycle[wr_ptr] <= sched_cycle;
            mem_bit[wr_ptr]   <= sched_bit;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_count               <= '0;
            fifo_count                <= '0;
            wr_ptr                    <= '0;
            rd_ptr                    <= '0;
            verinject__injector_state <= CODE_IDLE;
            missed                    <= 1'b0;
            bad_entry                 <= 1'b0;
            inject_count              <= '0;
        end else begin
            fifo_count                <= count_next;
            verinject__injector_state <= state_next;
            if (run) begin
                cycle_count <= cycle_count + CYC_ONE;
            end
            if (store) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !store) begin
                bad_entry <= 1'b1;
            end
            if (stale) begin
                missed <= 1'b1;
            end
            if (fire && (inject_count != 16'hFFFF)) begin
                inject_count <= inject_count + 16'd1;
            end
        end
    end
endmodule

// File: doc/verinject_injection_sequencer.md
Name: verinject_injection_sequencer

Overview:
Upstream driver of the shared 32-bit `verinject__injector_state` bus consumed by every FF and memory injector in the design. It holds a small in-order schedule of (cycle, bit index) fault entries and runs a free-running cycle counter. When the counter reaches an entry's cycle, it broadcasts that bit index for exactly one cycle. It also issues the buffer-reset code on request and parks the bus at the idle code otherwise.

Parameters:
FIFO_DEPTH, 8, number of schedule entries; must be a power of 2, at least 2.
CYCLE_W, 32, width of the cycle counter and of schedule cycle stamps.

Ports:
clock  input  1  sole clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
run  input  1  counter enable; the counter and firing advance only while high.
sched_valid  input  1  schedule entry offered.
sched_ready  output  1  schedule FIFO can accept an entry.
sched_cycle  input  CYCLE_W  cycle stamp at which the entry fires.
sched_bit  input  32  global bit index broadcast when the entry fires.
clear_req  input  1  request one-cycle buffer-reset broadcast.
cycle_count  output  CYCLE_W  current counter value.
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries held.
verinject__injector_state  output  32  registered broadcast to all injectors.
missed  output  1  sticky: a stale entry was discarded.
bad_entry  output  1  sticky: an entry with a reserved bit index was discarded.
inject_count  output  16  fires issued; saturates at 0xFFFF.

Behaviour:
- Codes on `verinject__injector_state`:
  - 0xFFFF_FFFF = idle.
  - 0xFFFF_FFFE = reset injector buffers.
  - Any other value = flip that global bit.
  - The output is a register and holds each code for exactly one cycle unless re-driven.
- Reset (async assert): cycle_count=0, FIFO empty, fifo_count=0, state=0xFFFF_FFFF, missed=0, bad_entry=0, inject_count=0. Release is synchronous to clock.
- Counter: increments by 1 at each edge with run=1. Wraps 2^CYCLE_W-1 -> 0. Holds when run=0.
- Push:
  - Handshake completes when sched_valid && sched_ready at an edge.
  - sched_ready = (fifo_count < FIFO_DEPTH), derived from registered count. When full, ready stays low even if a pop occurs the same cycle.
  - Entries with sched_bit of 0xFFFF_FFFE or 0xFFFF_FFFF are accepted but not stored, and set bad_entry.
  - Entries must be pushed in nondecreasing cycle order; the block does not sort.
- Per-edge decision, evaluated on the registered head and the current cycle_count (value before increment). Priority, highest first:
  1. clear_req=1: state <= 0xFFFF_FFFE. Head is not popped.
  2. run=1, FIFO not empty, head.cycle == cycle_count: state <= head.bit, pop, inject_count++ (saturating).
  3. run=1, FIFO not empty, head.cycle < cycle_count (unsigned): pop, missed <= 1, state <= idle.
  4. Otherwise state <= idle.
- Latency: an entry stamped N is visible on the bus during the cycle after the edge at which cycle_count==N. Every injector therefore sees a constant one-cycle offset.
- At most one pop per edge.
  - Duplicate stamps: the second entry becomes stale next edge and is counted as missed.
  - A fire coincident with clear_req also becomes missed.
- Push into an empty FIFO at cycle N with stamp N: not eligible until the next edge, so it is missed. The software schedule keeps a lead of at least 2 cycles.
- Simultaneous push and pop when not full: fifo_count unchanged; FIFO order preserved.
- run=0: no fire or stale pops. clear_req is still honoured.
- Counter wrap: unsigned compare, no wrap-aware ordering. Schedules do not span a wrap.
- Reset mid-operation discards all pending entries and any in-flight code; the bus returns to idle immediately.

Test Plan:
1. Reset, run=1, push (cycle 10, bit 5) -> state=5 for exactly one cycle when cycle_count=11; idle elsewhere; inject_count=1.
2. Push 8 entries with stamps 20..27 -> sched_ready low after the 8th push; bits broadcast on 8 consecutive cycles; fifo_count returns to 0; ready high again.
3. Push two entries stamped 30 (bits 1, 2) -> bit 1 fires; bit 2 discarded next edge; missed=1; state never shows 2.
4. clear_req at cycle_count=40 with head stamped 40 -> state=0xFFFF_FFFE for one cycle; head then discarded as missed.
5. Push sched_bit=0xFFFF_FFFE -> fifo_count unchanged, bad_entry=1; run=0 for 5 cycles holds cycle_count and emits only idle.
6. Assert reset with 3 entries pending while state=7 -> all outputs to reset values asynchronously before the next edge.
